// File: rtl/usb_tx_sched.sv
// Transmit scheduler for the bulk endpoint's single usb_tx engine: arbitrates
// handshake vs. bulk-IN data, launches packets, and retries data on ACK timeout.
module usb_tx_sched #(
  parameter int MAX_SIZE       = 64,
  parameter int ADDR_W         = 6,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRY      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hs_req,
  input  logic              hs_type,
  output logic              hs_done,
  input  logic              data_req,
  input  logic [6:0]        data_size,
  output logic              data_done,
  output logic              data_fail,
  output logic [ADDR_W-1:0] buf_rd_addr,
  input  logic [7:0]        buf_rd_data,
  output logic [7:0]        tx_packet_data,
  output logic [1:0]        tx_packet,
  output logic [6:0]        tx_packet_size,
  input  logic              get_tx_packet_data,
  input  logic              tx_done,
  input  logic              rx_ack
);

  // The byte counter must be able to hold MAX_SIZE itself (one past the last
  // byte), which can need one bit more than the read address.
  localparam int CNT_W = (ADDR_W > 7) ? ADDR_W : 7;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [6:0]       MAX_SIZE_7 = 7'(MAX_SIZE);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX    = RTY_W'(MAX_RETRY);

  localparam logic [1:0] PKT_NONE = 2'b00;
  localparam logic [1:0] PKT_DATA = 2'b01;
  localparam logic [1:0] PKT_ACK  = 2'b10;
  localparam logic [1:0] PKT_NAK  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_ACK
  } state_t;

  state_t           state;
  logic             is_hs;
  logic [CNT_W-1:0] byte_cnt;
  logic [TMR_W-1:0] timer;
  logic [RTY_W-1:0] retry_cnt;
  logic [6:0]       size_clamped;
  logic             pulse_busy;

  assign size_clamped   = (data_size > MAX_SIZE_7) ? MAX_SIZE_7 : data_size;
  assign buf_rd_addr    = byte_cnt[ADDR_W-1:0];
  assign tx_packet_data = buf_rd_data;

  // Requesters drop their level only after seeing the done/fail pulse, so no
  // grant is allowed in the cycle that pulse is high.
  assign pulse_busy = hs_done | data_done | data_fail;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      is_hs          <= 1'b0;
      byte_cnt       <= '0;
      timer          <= '0;
      retry_cnt      <= '0;
      tx_packet      <= PKT_NONE;
      tx_packet_size <= '0;
      hs_done        <= 1'b0;
      data_done      <= 1'b0;
      data_fail      <= 1'b0;
    end else begin
      hs_done   <= 1'b0;
      data_done <= 1'b0;
      data_fail <= 1'b0;

      case (state)
        IDLE: begin
          if (!pulse_busy && (hs_req || data_req)) begin
            is_hs          <= hs_req;
            tx_packet      <= hs_req ? (hs_type ? PKT_NAK : PKT_ACK) : PKT_DATA;
            tx_packet_size <= size_clamped;
            retry_cnt      <= '0;
            byte_cnt       <= '0;
            state          <= LOAD;
          end
        end

        LOAD: begin
          tx_packet <= PKT_NONE;
          state     <= SEND;
        end

        SEND: begin
          if (get_tx_packet_data && (byte_cnt < CNT_W'(tx_packet_size))) begin
            byte_cnt <= byte_cnt + 1'b1;
          end
          if (tx_done) begin
            if (is_hs) begin
              hs_done <= 1'b1;
              state   <= IDLE;
            end else begin
              timer <= '0;
              state <= WAIT_ACK;
            end
          end
        end

        WAIT_ACK: begin
          timer <= timer + 1'b1;
          // An ACK arriving on the expiry cycle still counts as success.
          if (rx_ack) begin
            data_done <= 1'b1;
            state     <= IDLE;
          end else if (timer == TMR_LAST) begin
            if (retry_cnt < RTY_MAX) begin
              retry_cnt <= retry_cnt + 1'b1;
              byte_cnt  <= '0;
              tx_packet <= PKT_DATA;
              state     <= LOAD;
            end else begin
              data_fail <= 1'b1;
              state     <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_sched.sv
// Scoreboard bench for usb_tx_sched: expected launches and done/fail pulses are
// queued as stimulus is applied and matched as the scheduler emits them.
module tb_usb_tx_sched;

  localparam int TO   = 1024;
  localparam int MAXS = 64;
  localparam int AW   = 7;

  localparam int EV_LAUNCH = 1;
  localparam int EV_HS     = 2;
  localparam int EV_DONE   = 3;
  localparam int EV_FAIL   = 4;

  logic          clk;
  logic          rst;
  logic          hs_req;
  logic          hs_type;
  logic          hs_done;
  logic          data_req;
  logic [6:0]    data_size;
  logic          data_done;
  logic          data_fail;
  logic [AW-1:0] buf_rd_addr;
  logic [7:0]    buf_rd_data;
  logic [7:0]    tx_packet_data;
  logic [1:0]    tx_packet;
  logic [6:0]    tx_packet_size;
  logic          get_tx_packet_data;
  logic          tx_done;
  logic          rx_ack;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  usb_tx_sched #(
    .MAX_SIZE(MAXS),
    .ADDR_W(AW),
    .TIMEOUT_CYCLES(TO),
    .MAX_RETRY(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hs_req(hs_req),
    .hs_type(hs_type),
    .hs_done(hs_done),
    .data_req(data_req),
    .data_size(data_size),
    .data_done(data_done),
    .data_fail(data_fail),
    .buf_rd_addr(buf_rd_addr),
    .buf_rd_data(buf_rd_data),
    .tx_packet_data(tx_packet_data),
    .tx_packet(tx_packet),
    .tx_packet_size(tx_packet_size),
    .get_tx_packet_data(get_tx_packet_data),
    .tx_done(tx_done),
    .rx_ack(rx_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Endpoint buffer model: a recognisable byte pattern per address.
  assign buf_rd_data = 8'(buf_rd_addr * 3 + 1);

  function automatic logic [31:0] ev(input int kind, input logic [1:0] code, input logic [6:0] size);
    return 32'((kind << 16) | (int'(code) << 8) | int'(size));
  endfunction

  function automatic logic [6:0] clampSize(input int s);
    return (s > MAXS) ? 7'(MAXS) : 7'(s);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic scoreEvent(input string tag, input logic [31:0] observed);
    if (exp_q.size() == 0) checkOutput({tag, "_unexpected"}, observed, 32'h0);
    else checkOutput(tag, observed, exp_q.pop_front());
  endtask

  // Output monitor: every launch cycle and every pulse is one scoreboard event.
  always @(negedge clk) begin
    if (tx_packet != 2'b00) scoreEvent("launch", ev(EV_LAUNCH, tx_packet, tx_packet_size));
    if (hs_done)   scoreEvent("hs_done", ev(EV_HS, 2'b00, 7'd0));
    if (data_done) scoreEvent("data_done", ev(EV_DONE, 2'b00, 7'd0));
    if (data_fail) scoreEvent("data_fail", ev(EV_FAIL, 2'b00, 7'd0));
  end

  task automatic applyStimulus(input logic hs, input logic nak, input logic dat, input int size);
    hs_req    = hs;
    hs_type   = nak;
    data_req  = dat;
    data_size = 7'(size);
  endtask

  task automatic pulseTxDone();
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic pulseRxAck();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  task automatic fetchBytes(input int n);
    for (int j = 0; j < n; j++) begin
      get_tx_packet_data = 1'b1;
      @(negedge clk);
    end
    get_tx_packet_data = 1'b0;
  endtask

  task automatic waitEvent(output int cycles);
    cycles = 0;
    while (!(tx_packet != 2'b00 || data_fail || data_done || hs_done) && cycles < 4 * TO) begin
      @(negedge clk);
      cycles++;
    end
    if (cycles >= 4 * TO) checkOutput("wait_budget", 32'(cycles), 32'(4 * TO - 1));
  endtask

  initial begin
    int gap;
    rst = 1'b1;
    get_tx_packet_data = 1'b0;
    tx_done = 1'b0;
    rx_ack = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 0);
    repeat (3) @(negedge clk);
    checkOutput("rst_pkt", 32'(tx_packet), 32'd0);
    checkOutput("rst_size", 32'(tx_packet_size), 32'd0);
    checkOutput("rst_addr", 32'(buf_rd_addr), 32'd0);
    checkOutput("rst_pulses", {29'd0, hs_done, data_done, data_fail}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] handshake NAK");
    applyStimulus(1'b1, 1'b1, 1'b0, 0);
    exp_q.push_back(ev(EV_LAUNCH, 2'b11, 7'd0));
    exp_q.push_back(ev(EV_HS, 2'b00, 7'd0));
    @(negedge clk);
    checkOutput("nak_code", 32'(tx_packet), 32'd3);
    @(negedge clk);
    checkOutput("nak_one_cycle", 32'(tx_packet), 32'd0);
    repeat (2) @(negedge clk);
    pulseTxDone();
    checkOutput("nak_hsdone", 32'(hs_done), 32'd1);
    checkOutput("nak_addr", 32'(buf_rd_addr), 32'd0);
    hs_req = 1'b0;
    @(negedge clk);
    checkOutput("hsdone_one_cycle", 32'(hs_done), 32'd0);

    $display("[TB] data size 8");
    applyStimulus(1'b0, 1'b0, 1'b1, 8);
    exp_q.push_back(ev(EV_LAUNCH, 2'b01, 7'd8));
    exp_q.push_back(ev(EV_DONE, 2'b00, 7'd0));
    @(negedge clk);
    checkOutput("d8_size", 32'(tx_packet_size), 32'd8);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      checkOutput("d8_addr", 32'(buf_rd_addr), 32'(i));
      checkOutput("d8_byte", 32'(tx_packet_data), 32'(8'(i * 3 + 1)));
      get_tx_packet_data = 1'b1;
      @(negedge clk);
      get_tx_packet_data = 1'b0;
    end
    checkOutput("d8_addr_end", 32'(buf_rd_addr), 32'd8);
    pulseTxDone();
    repeat (10) @(negedge clk);
    pulseRxAck();
    checkOutput("d8_done", 32'(data_done), 32'd1);
    data_req = 1'b0;
    @(negedge clk);

    $display("[TB] retries to failure");
    applyStimulus(1'b0, 1'b0, 1'b1, 4);
    for (int k = 0; k < 4; k++) exp_q.push_back(ev(EV_LAUNCH, 2'b01, 7'd4));
    exp_q.push_back(ev(EV_FAIL, 2'b00, 7'd0));
    @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      checkOutput("r_load_addr", 32'(buf_rd_addr), 32'd0);
      @(negedge clk);
      fetchBytes(4);
      checkOutput("r_addr4", 32'(buf_rd_addr), 32'd4);
      pulseTxDone();
      waitEvent(gap);
      checkOutput("r_gap", 32'(gap), 32'(TO));
      if (a < 3) checkOutput("r_relaunch", 32'(tx_packet), 32'd1);
      else begin
        checkOutput("r_fail", 32'(data_fail), 32'd1);
        data_req = 1'b0;
      end
    end
    @(negedge clk);

    $display("[TB] simultaneous requests and ACK on expiry");
    applyStimulus(1'b1, 1'b0, 1'b1, 5);
    exp_q.push_back(ev(EV_LAUNCH, 2'b10, clampSize(5)));
    exp_q.push_back(ev(EV_HS, 2'b00, 7'd0));
    exp_q.push_back(ev(EV_LAUNCH, 2'b01, clampSize(5)));
    exp_q.push_back(ev(EV_DONE, 2'b00, 7'd0));
    @(negedge clk);
    checkOutput("both_first", 32'(tx_packet), 32'd2);
    @(negedge clk);
    pulseTxDone();
    checkOutput("both_hsdone", 32'(hs_done), 32'd1);
    hs_req = 1'b0;
    @(negedge clk);
    checkOutput("both_gap", 32'(tx_packet), 32'd0);
    @(negedge clk);
    checkOutput("both_data", 32'(tx_packet), 32'd1);
    @(negedge clk);
    pulseTxDone();
    repeat (TO - 1) @(negedge clk);
    pulseRxAck();
    checkOutput("edge_done", 32'(data_done), 32'd1);
    data_req = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("edge_no_relaunch", 32'(tx_packet), 32'd0);

    $display("[TB] clamp and zero length");
    applyStimulus(1'b0, 1'b0, 1'b1, 100);
    exp_q.push_back(ev(EV_LAUNCH, 2'b01, clampSize(100)));
    exp_q.push_back(ev(EV_DONE, 2'b00, 7'd0));
    repeat (2) @(negedge clk);
    fetchBytes(70);
    checkOutput("sat_addr", 32'(buf_rd_addr), 32'd64);
    pulseTxDone();
    repeat (3) @(negedge clk);
    pulseRxAck();
    data_req = 1'b0;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 0);
    exp_q.push_back(ev(EV_LAUNCH, 2'b01, 7'd0));
    exp_q.push_back(ev(EV_DONE, 2'b00, 7'd0));
    @(negedge clk);
    checkOutput("zero_size", 32'(tx_packet_size), 32'd0);
    @(negedge clk);
    fetchBytes(1);
    checkOutput("zero_addr", 32'(buf_rd_addr), 32'd0);
    pulseTxDone();
    pulseRxAck();
    checkOutput("zero_done", 32'(data_done), 32'd1);
    data_req = 1'b0;
    @(negedge clk);

    $display("[TB] stray tx_done and rx_ack in IDLE");
    pulseTxDone();
    pulseRxAck();
    repeat (2) @(negedge clk);
    checkOutput("idle_quiet", 32'(tx_packet), 32'd0);

    $display("[TB] reset during WAIT_ACK");
    applyStimulus(1'b0, 1'b0, 1'b1, 3);
    exp_q.push_back(ev(EV_LAUNCH, 2'b01, 7'd3));
    repeat (2) @(negedge clk);
    fetchBytes(3);
    pulseTxDone();
    repeat (5) @(negedge clk);
    checkOutput("pre_rst_addr", 32'(buf_rd_addr), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_pkt", 32'(tx_packet), 32'd0);
    checkOutput("mid_rst_size", 32'(tx_packet_size), 32'd0);
    checkOutput("mid_rst_addr", 32'(buf_rd_addr), 32'd0);
    checkOutput("mid_rst_pulses", {29'd0, hs_done, data_done, data_fail}, 32'd0);
    rst = 1'b0;
    exp_q.push_back(ev(EV_LAUNCH, 2'b01, 7'd3));
    exp_q.push_back(ev(EV_DONE, 2'b00, 7'd0));
    @(negedge clk);
    checkOutput("regrant", 32'(tx_packet), 32'd1);
    @(negedge clk);
    pulseTxDone();
    pulseRxAck();
    data_req = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
